// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex receiver: FSM state encoding,
// ASCII constants and the bit-time helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_UA  = 8'h41;
    localparam logic [7:0] ASCII_UF  = 8'h46;
    localparam logic [7:0] ASCII_LA  = 8'h61;
    localparam logic [7:0] ASCII_LF_ = 8'h66;

    // Last count value of one bit period (counter runs 0..BIT_T).
    function automatic int bit_time(input int clk_freq, input int baud);
        return clk_freq / baud - 1;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART frame receiver: 2-FF synchroniser, start/data/stop FSM, baud and
// bit counters. Frame is 8N1, or 8E1 when UART_PARITY_EN is defined.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   rx_byte        last correctly framed byte
//   rx_byte_valid  one-cycle pulse per good byte
//   frame_err      one-cycle pulse on bad stop (or parity) bit
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);

    localparam int BIT_T = bit_time(CLK_FREQ, BAUD);
    localparam int CW    = $clog2(BIT_T + 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_T);
    localparam logic [CW-1:0] HALF = CW'(BIT_T / 2);

    logic sync1, rx_s, rx_prev, fall;

    rx_state_t      state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shreg, sh_n;
    logic [7:0]     byte_n;
    logic           bv_n, fe_n;

    // Synchroniser resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_n;
            shreg         <= sh_n;
            rx_byte       <= byte_n;
            rx_byte_valid <= bv_n;
            frame_err     <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = shreg;
        byte_n  = rx_byte;
        bv_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (fall) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF) begin
                    cnt_n = '0;
                    bit_n = '0;
                    // Line back high at mid start bit: noise, not a frame.
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, shreg[7:1]};
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    // Even parity: parity bit must equal XOR of data.
                    if (rx_s != ^shreg) begin
                        fe_n    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (rx_s) begin
                        byte_n = shreg;
                        bv_n   = 1'b1;
                    end else begin
                        fe_n = 1'b1;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_hex_rx.sv
// UART receiver plus ASCII-hex parser producing a right-justified 24-bit
// value. Optional 8E1 framing via the UART_PARITY_EN macro.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx                  serial line, idle high
//   data_out/data_valid committed hex value and its one-cycle strobe
//   rx_byte/rx_byte_valid  last good byte and its strobe
//   frame_err           one-cycle pulse on a framing/parity error
module uart_hex_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        frame_err
);

    logic [23:0] dbuf;
    logic [2:0]  dcnt;
    logic [3:0]  nib;
    logic        is_dig, is_eol, is_esc;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err)
    );

    always_comb begin
        is_dig = 1'b0;
        nib    = 4'h0;
        if (rx_byte >= ASCII_0 && rx_byte <= ASCII_9) begin
            is_dig = 1'b1;
            nib    = 4'(rx_byte - ASCII_0);
        end else if (rx_byte >= ASCII_UA && rx_byte <= ASCII_UF) begin
            is_dig = 1'b1;
            nib    = 4'(rx_byte - ASCII_UA + 8'd10);
        end else if (rx_byte >= ASCII_LA && rx_byte <= ASCII_LF_) begin
            is_dig = 1'b1;
            nib    = 4'(rx_byte - ASCII_LA + 8'd10);
        end
    end

    assign is_eol = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
    assign is_esc = (rx_byte == ASCII_ESC);

    always_ff @(posedge clk) begin
        if (rst) begin
            dbuf       <= '0;
            dcnt       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rx_byte_valid) begin
                if (is_dig) begin
                    // Keep shifting past six so the last six digits win.
                    dbuf <= {dbuf[19:0], nib};
                    if (dcnt != 3'd6) dcnt <= dcnt + 3'd1;
                end else if (is_eol && dcnt != 3'd0) begin
                    data_out   <= dbuf;
                    data_valid <= 1'b1;
                    dbuf       <= '0;
                    dcnt       <= '0;
                end else if (is_esc) begin
                    dbuf <= '0;
                    dcnt <= '0;
                end
            end
        end
    end

endmodule
